jt49_bus_seq: RTL and testbench

// Upstream sequencer for the JT49 BDIR/BC1 bus wrapper. It takes simple CPU-side register read and write requests through a valid/ready handshake and buffers them in a small FIFO.
// It expands each request into the pin sequence the PSG bus expects: address latch, inactive, write or read, inactive.

---
 rtl/jt49_bus_seq.sv | 209 ++++++++++++++++++++
 tb/tb_jt49_bus_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_bus_seq.sv
// Request sequencer for the JT49 BDIR/BC1 bus: queues CPU register reads/writes
// and plays each one out as LATCH, gap, ACCESS, gap on registered bus pins.
module jt49_bus_seq #(
    parameter int FIFO_AW = 2,
    parameter int HOLD    = 1,
    parameter int GAP     = 1,
    parameter int RD_LAT  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] bus_dout,
    input  logic [7:0] bus_din
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] CNT_ZERO = {(FIFO_AW + 1){1'b0}};
    // Five bits so a long read access (HOLD + RD_LAT) still fits in one phase.
    localparam logic [4:0] HOLD_LD = 5'(HOLD - 1);
    localparam logic [4:0] GAP_LD  = 5'(GAP - 1);
    localparam logic [4:0] RD_LD   = 5'(HOLD + RD_LAT - 1);
    localparam logic       GAP_EN  = (GAP != 0);

    localparam logic [1:0] CODE_INACT = 2'b00;
    localparam logic [1:0] CODE_READ  = 2'b01;
    localparam logic [1:0] CODE_WRITE = 2'b10;
    localparam logic [1:0] CODE_LATCH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_GAP_A  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_GAP_B  = 3'd4
    } state_t;

    logic [12:0]        fifo_mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic               push_s;
    logic               pop_s;
    logic               fifo_empty_s;
    logic [12:0]        head_s;

    state_t     state_r, state_s;
    logic [4:0] cnt_r, cnt_s;
    logic [1:0] code_r, code_s;
    logic [7:0] dout_r, dout_s;
    logic       cur_we_r;
    logic [7:0] cur_data_r;
    logic       rd_valid_r;
    logic [7:0] rd_data_r;
    logic       capture_s;
    logic       go_latch_s, go_gap_a_s, go_access_s, go_gap_b_s, go_idle_s;

    assign fifo_empty_s = (count_r == CNT_ZERO);
    assign req_ready    = (count_r != CNT_FULL);
    assign push_s       = req_valid & req_ready;
    assign head_s       = fifo_mem_r[rd_ptr_r];

    // Request storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {req_we, req_addr, req_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Phase sequencing: decide the transition, then set the next pin values.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        code_s      = code_r;
        dout_s      = dout_r;
        pop_s       = 1'b0;
        capture_s   = 1'b0;
        go_latch_s  = 1'b0;
        go_gap_a_s  = 1'b0;
        go_access_s = 1'b0;
        go_gap_b_s  = 1'b0;
        go_idle_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) go_latch_s = 1'b1;
                else               go_idle_s  = 1'b1;
            end
            ST_LATCH: begin
                if (cnt_r != 5'd0) go_idle_s = 1'b0;
                else if (GAP_EN)   go_gap_a_s = 1'b1;
                else               go_access_s = 1'b1;
            end
            ST_GAP_A: begin
                if (cnt_r != 5'd0) go_idle_s = 1'b0;
                else               go_access_s = 1'b1;
            end
            ST_ACCESS: begin
                if (cnt_r != 5'd0) begin
                    go_idle_s = 1'b0;
                end else begin
                    capture_s = ~cur_we_r;
                    if (GAP_EN)             go_gap_b_s = 1'b1;
                    else if (!fifo_empty_s) go_latch_s = 1'b1;
                    else                    go_idle_s  = 1'b1;
                end
            end
            ST_GAP_B: begin
                if (cnt_r != 5'd0)      go_idle_s  = 1'b0;
                else if (!fifo_empty_s) go_latch_s = 1'b1;
                else                    go_idle_s  = 1'b1;
            end
            default: go_idle_s = 1'b1;
        endcase

        if (go_latch_s) begin
            state_s = ST_LATCH;
            cnt_s   = HOLD_LD;
            code_s  = CODE_LATCH;
            dout_s  = {4'h0, head_s[11:8]};
            pop_s   = 1'b1;
        end else if (go_gap_a_s) begin
            state_s = ST_GAP_A;
            cnt_s   = GAP_LD;
            code_s  = CODE_INACT;
            dout_s  = dout_r;
        end else if (go_access_s) begin
            state_s = ST_ACCESS;
            if (cur_we_r) begin
                cnt_s  = HOLD_LD;
                code_s = CODE_WRITE;
                dout_s = cur_data_r;
            end else begin
                cnt_s  = RD_LD;
                code_s = CODE_READ;
                dout_s = 8'h00;
            end
        end else if (go_gap_b_s) begin
            state_s = ST_GAP_B;
            cnt_s   = GAP_LD;
            code_s  = CODE_INACT;
            dout_s  = 8'h00;
        end else if (go_idle_s) begin
            state_s = ST_IDLE;
            cnt_s   = 5'd0;
            code_s  = CODE_INACT;
            dout_s  = 8'h00;
        end else begin
            cnt_s = cnt_r - 5'd1;
        end
    end

    // FSM, pin and read-return registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 5'd0;
            code_r     <= CODE_INACT;
            dout_r     <= 8'h00;
            cur_we_r   <= 1'b0;
            cur_data_r <= 8'h00;
            rd_valid_r <= 1'b0;
            rd_data_r  <= 8'h00;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            code_r     <= code_s;
            dout_r     <= dout_s;
            rd_valid_r <= capture_s;
            if (pop_s) begin
                cur_we_r   <= head_s[12];
                cur_data_r <= head_s[7:0];
            end
            if (capture_s) rd_data_r <= bus_din;
        end
    end

    assign bdir     = code_r[1];
    assign bc1      = code_r[0];
    assign bus_dout = dout_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign busy     = !fifo_empty_s || (state_r != ST_IDLE);

endmodule

// File: tb/tb_jt49_bus_seq.sv
// Bench for jt49_bus_seq: a schedule-based reference model predicts the bus
// trace, read returns and busy/ready per cycle; a PSG register model answers reads.
module tb_jt49_bus_seq;
    localparam int MAXC  = 2048;
    localparam int H     = 1;
    localparam int G     = 1;
    localparam int R     = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       psg_clr;
    logic       req_valid, req_we, req_ready, rd_valid, busy, bdir, bc1;
    logic [3:0] req_addr;
    logic [7:0] req_data, rd_data, bus_dout, bus_din;
    logic       req_valid2, req_we2, req_ready2, rd_valid2, busy2, bdir2, bc12;
    logic [3:0] req_addr2;
    logic [7:0] req_data2, rd_data2, bus_dout2, bus_din2;

    jt49_bus_seq #(.FIFO_AW(2), .HOLD(H), .GAP(G), .RD_LAT(R)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .bdir(bdir),
        .bc1(bc1), .bus_dout(bus_dout), .bus_din(bus_din));

    jt49_bus_seq #(.FIFO_AW(2), .HOLD(2), .GAP(0), .RD_LAT(1)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we2), .req_addr(req_addr2), .req_data(req_data2),
        .rd_valid(rd_valid2), .rd_data(rd_data2), .busy(busy2), .bdir(bdir2),
        .bc1(bc12), .bus_dout(bus_dout2), .bus_din(bus_din2));

    assign bus_din2 = 8'h3C;

    // PSG register file on the first instance's bus
    logic [7:0] psg_reg [16];
    logic [3:0] psg_lat;
    assign bus_din = psg_reg[psg_lat];
    always @(posedge clk) begin
        if (psg_clr) begin
            for (int i = 0; i < 16; i++) psg_reg[i] <= 8'(i) * 8'h11;
            psg_reg[3] <= 8'hA5;
            psg_lat    <= 4'h0;
        end else if ({bdir, bc1} == 2'b11) begin
            psg_lat <= bus_dout[3:0];
        end else if ({bdir, bc1} == 2'b10) begin
            psg_reg[psg_lat] <= bus_dout;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int base    = 0;

    // reference model state
    logic [9:0] exp_bus  [MAXC];
    logic       exp_rdv  [MAXC];
    logic [7:0] exp_rdd  [MAXC];
    logic       exp_busy [MAXC];
    int         acc_q[$];
    int         start_q[$];
    int         prev_end;
    logic [7:0] mreg [16];
    logic [7:0] mreg_save [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic init_model();
        for (int j = 0; j < MAXC; j++) begin
            exp_bus[j] = 10'h000; exp_rdv[j] = 1'b0; exp_rdd[j] = 8'h00; exp_busy[j] = 1'b0;
        end
        acc_q.delete();
        start_q.delete();
        prev_end = 0;
    endtask

    function automatic int model_count(input int e);
        int n = 0;
        foreach (acc_q[i])   if (acc_q[i] <= e)   n++;
        foreach (start_q[i]) if (start_q[i] <= e) n--;
        return n;
    endfunction

    // request accepted at edge t: place its whole bus trace on the timeline
    task automatic schedule(input int t, input logic we, input logic [3:0] a, input logic [7:0] d);
        int s, len, acc, alen;
        s    = (t + 1 > prev_end) ? t + 1 : prev_end;
        alen = we ? H : H + R;
        len  = 2 * H + 2 * G + (we ? 0 : R);
        if (s + len + 4 >= MAXC) begin
            $display("FAIL model_overflow at cycle %0d", cyc);
            $fatal(1);
        end
        acc = s + H + G;
        for (int k = 0; k < H; k++) exp_bus[s + k] = {2'b11, 4'h0, a};
        for (int k = 0; k < G; k++) exp_bus[s + H + k] = {2'b00, 4'h0, a};
        for (int k = 0; k < alen; k++) exp_bus[acc + k] = we ? {2'b10, d} : {2'b01, 8'h00};
        for (int k = 0; k < G; k++) exp_bus[acc + alen + k] = 10'h000;
        if (we) begin
            mreg[a] = d;
        end else begin
            exp_rdv[acc + alen] = 1'b1;
            for (int j = acc + alen; j < MAXC; j++) exp_rdd[j] = mreg[a];
        end
        for (int j = t; j < s + len; j++) exp_busy[j] = 1'b1;
        acc_q.push_back(t);
        start_q.push_back(s);
        prev_end = s + len;
    endtask

    task automatic tick(input logic v, input logic we, input logic [3:0] a,
                        input logic [7:0] d, output logic taken);
        int  e;
        logic mr;
        e  = cyc - base;
        mr = (model_count(e) < DEPTH);
        chk("req_ready", req_ready, mr);
        req_valid = v; req_we = we; req_addr = a; req_data = d;
        taken = v & mr;
        if (taken) schedule(e + 1, we, a, d);
        @(posedge clk); cyc++;
        @(negedge clk);
        e = e + 1;
        chk("bus", {bdir, bc1, bus_dout}, exp_bus[e]);
        chk("rd_valid", rd_valid, exp_rdv[e]);
        chk("rd_data", rd_data, exp_rdd[e]);
        chk("busy", busy, exp_busy[e]);
        req_valid = 1'b0;
    endtask

    task automatic send(input logic we, input logic [3:0] a, input logic [7:0] d);
        logic taken = 1'b0;
        for (int i = 0; i < 50 && !taken; i++) tick(1'b1, we, a, d, taken);
        if (!taken) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        logic tk;
        for (int i = 0; i < 600 && (cyc - base) < prev_end + 2; i++) tick(1'b0, 1'b0, 4'h0, 8'h00, tk);
        chk("drain_idle", busy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0;
        @(posedge clk); cyc++;
        @(negedge clk);
        chk("rst_bus", {bdir, bc1, bus_dout}, 10'h000);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        rst = 1'b0;
        init_model();
        base = cyc;
    endtask

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [1:0] code;
        logic [7:0] dout;
        logic       rdv;
        logic [7:0] rdd;
        logic       bsy;
    } cyc_t;

    vec_t vecs [9];
    cyc_t w2 [6];
    cyc_t r2 [8];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic       tk, seen_low, v;
        logic       rw;
        logic [3:0] ra, baddr;
        logic [7:0] rd8;
        int         issued;

        vecs[0] = '{1'b1, 4'd7,  8'h38, 8'h00};
        vecs[1] = '{1'b0, 4'd3,  8'h00, 8'hA5};
        vecs[2] = '{1'b1, 4'd8,  8'h0F, 8'h00};
        vecs[3] = '{1'b0, 4'd8,  8'h00, 8'h0F};
        vecs[4] = '{1'b1, 4'd3,  8'h5A, 8'h00};
        vecs[5] = '{1'b0, 4'd3,  8'h00, 8'h5A};
        vecs[6] = '{1'b0, 4'd2,  8'h00, 8'h22};
        vecs[7] = '{1'b1, 4'd15, 8'hC3, 8'h00};
        vecs[8] = '{1'b0, 4'd15, 8'h00, 8'hC3};

        w2[0] = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b1};
        w2[1] = '{2'b11, 8'h00, 1'b0, 8'h00, 1'b1};
        w2[2] = '{2'b11, 8'h00, 1'b0, 8'h00, 1'b1};
        w2[3] = '{2'b10, 8'hFF, 1'b0, 8'h00, 1'b1};
        w2[4] = '{2'b10, 8'hFF, 1'b0, 8'h00, 1'b1};
        w2[5] = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b0};
        r2[0] = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b1};
        r2[1] = '{2'b11, 8'h09, 1'b0, 8'h00, 1'b1};
        r2[2] = '{2'b11, 8'h09, 1'b0, 8'h00, 1'b1};
        r2[3] = '{2'b01, 8'h00, 1'b0, 8'h00, 1'b1};
        r2[4] = '{2'b01, 8'h00, 1'b0, 8'h00, 1'b1};
        r2[5] = '{2'b01, 8'h00, 1'b0, 8'h00, 1'b1};
        r2[6] = '{2'b00, 8'h00, 1'b1, 8'h3C, 1'b0};
        r2[7] = '{2'b00, 8'h00, 1'b0, 8'h3C, 1'b0};

        for (int i = 0; i < 16; i++) mreg[i] = 8'(i) * 8'h11;
        mreg[3] = 8'hA5;
        rst = 1'b1; psg_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 4'h0; req_data = 8'h00;
        req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = 4'h0; req_data2 = 8'h00;
        @(posedge clk); cyc++;
        @(negedge clk);
        psg_clr = 1'b0;
        do_reset();

        // directed single transactions from the vector table
        foreach (vecs[i]) begin
            send(vecs[i].we, vecs[i].addr, vecs[i].data);
            drain();
            if (!vecs[i].we) chk("vec_rd_data", rd_data, vecs[i].exp_rd);
        end

        // burst of six writes against a four-deep FIFO
        do_reset();
        seen_low = 1'b0;
        for (int i = 0; i < 6; i++) begin
            baddr = 4'(i < 3 ? 4 + i : 6 + i);
            tk = 1'b0;
            for (int g = 0; g < 50 && !tk; g++) begin
                if (!req_ready) seen_low = 1'b1;
                tick(1'b1, 1'b1, baddr, 8'(8'h60 + i), tk);
            end
            if (!tk) chk("burst_accept", 32'd0, 32'd1);
        end
        drain();
        chk("burst_full_seen", seen_low, 1'b1);
        for (int i = 0; i < 6; i++) begin
            baddr = 4'(i < 3 ? 4 + i : 6 + i);
            chk("burst_psg_reg", psg_reg[baddr], 8'(8'h60 + i));
        end

        // randomized traffic against the schedule model
        do_reset();
        issued = 0;
        rw = 1'(($urandom & 32'd1)); ra = 4'($urandom); rd8 = 8'($urandom);
        for (int i = 0; i < 500 && issued < 60; i++) begin
            v = ($urandom_range(0, 9) < 6);
            tick(v, rw, ra, rd8, tk);
            if (tk) begin
                issued++;
                rw = 1'(($urandom & 32'd1)); ra = 4'($urandom); rd8 = 8'($urandom);
            end
        end
        drain();
        chk("rand_issued", issued, 60);

        // reset in the middle of a read with two writes still queued
        do_reset();
        mreg_save = mreg;
        tick(1'b1, 1'b0, 4'd5, 8'h00, tk);
        tick(1'b1, 1'b1, 4'd6, 8'h11, tk);
        tick(1'b1, 1'b1, 4'd7, 8'h22, tk);
        tick(1'b0, 1'b0, 4'd0, 8'h00, tk);
        chk("midrst_in_read", {bdir, bc1}, 2'b01);
        do_reset();
        mreg = mreg_save;
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 4'd0, 8'h00, tk);
        chk("midrst_reg6", psg_reg[6], mreg[6]);
        chk("midrst_reg7", psg_reg[7], mreg[7]);

        // second instance: HOLD=2, GAP=0, RD_LAT=1
        chk("d2_ready", req_ready2, 1'b1);
        req_valid2 = 1'b1; req_we2 = 1'b1; req_addr2 = 4'd0; req_data2 = 8'hFF;
        @(posedge clk); cyc++;
        @(negedge clk);
        req_valid2 = 1'b0;
        foreach (w2[k]) begin
            chk("d2_wr_bus", {bdir2, bc12, bus_dout2}, {w2[k].code, w2[k].dout});
            chk("d2_wr_busy", busy2, w2[k].bsy);
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = 4'd9; req_data2 = 8'h00;
        @(posedge clk); cyc++;
        @(negedge clk);
        req_valid2 = 1'b0;
        foreach (r2[k]) begin
            chk("d2_rd_bus", {bdir2, bc12, bus_dout2}, {r2[k].code, r2[k].dout});
            chk("d2_rd_valid", rd_valid2, r2[k].rdv);
            chk("d2_rd_data", rd_data2, r2[k].rdd);
            chk("d2_rd_busy", busy2, r2[k].bsy);
            @(posedge clk); cyc++;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
